// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional-N oversample/bit tick generator with four selectable rates
// Phase accumulator carry produces os_tick; every OVS-th os_tick is also a bit_tick.
module baud_gen_frac #(
  parameter int CLK_HZ = 100_000_000,
  parameter int OVS    = 8,
  parameter int ACC_W  = 24,
  parameter int BAUD0  = 9600,
  parameter int BAUD1  = 19200,
  parameter int BAUD2  = 57600,
  parameter int BAUD3  = 115200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              baud_sel,
  input  logic                    restart,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic [$clog2(OVS)-1:0]  os_phase,
  output logic [1:0]              active_sel
);

  localparam int PH_W = $clog2(OVS);
  localparam logic [63:0] SCALE = 64'd1 << ACC_W;

  function automatic logic [63:0] calc_inc(input logic [63:0] baud);
    return (baud * 64'(OVS) * SCALE + 64'(CLK_HZ) / 64'd2) / 64'(CLK_HZ);
  endfunction

  localparam logic [63:0] INC0_64 = calc_inc(64'(BAUD0));
  localparam logic [63:0] INC1_64 = calc_inc(64'(BAUD1));
  localparam logic [63:0] INC2_64 = calc_inc(64'(BAUD2));
  localparam logic [63:0] INC3_64 = calc_inc(64'(BAUD3));

  localparam logic [ACC_W-1:0] INC0 = INC0_64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] INC1 = INC1_64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] INC2 = INC2_64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] INC3 = INC3_64[ACC_W-1:0];

  if (OVS < 2) begin : g_ovs_chk
    $error("baud_gen_frac: OVS must be >= 2");
  end
  if (ACC_W < 16 || ACC_W > 32) begin : g_accw_chk
    $error("baud_gen_frac: ACC_W must be in 16..32");
  end
  // A zero or full-scale increment means BAUD*OVS is unreachable at this clock.
  if (INC0_64 == 64'd0 || INC0_64 >= SCALE || INC1_64 == 64'd0 || INC1_64 >= SCALE ||
      INC2_64 == 64'd0 || INC2_64 >= SCALE || INC3_64 == 64'd0 || INC3_64 >= SCALE) begin : g_inc_chk
    $error("baud_gen_frac: BAUD*OVS must be nonzero and below CLK_HZ");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_sel;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             last_phase;

  always_comb begin
    inc_sel = INC0;
    case (active_sel)
      2'd0:    inc_sel = INC0;
      2'd1:    inc_sel = INC1;
      2'd2:    inc_sel = INC2;
      default: inc_sel = INC3;
    endcase
  end

  assign sum        = {1'b0, acc} + {1'b0, inc_sel};
  assign carry      = sum[ACC_W];
  assign last_phase = (os_phase == PH_W'(OVS - 1));

  // Rate index only follows baud_sel at interval boundaries so no interval is distorted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      os_phase   <= '0;
      active_sel <= 2'd0;
      os_tick    <= 1'b0;
      bit_tick   <= 1'b0;
    end else if (restart) begin
      acc        <= '0;
      os_phase   <= '0;
      active_sel <= baud_sel;
      os_tick    <= 1'b0;
      bit_tick   <= 1'b0;
    end else if (!en) begin
      active_sel <= baud_sel;
      os_tick    <= 1'b0;
      bit_tick   <= 1'b0;
    end else begin
      acc      <= sum[ACC_W-1:0];
      os_tick  <= carry;
      bit_tick <= carry & last_phase;
      if (carry) begin
        os_phase   <= last_phase ? '0 : os_phase + PH_W'(1);
        active_sel <= baud_sel;
      end
    end
  end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Fractional-N, runtime-selectable baud tick generator for the UART/FIFO subsystem. It produces an oversample tick (`os_tick`, OVS per bit) and a bit tick (`bit_tick`) for the UART TX/RX datapaths. It replaces the fixed-divisor counter with a phase accumulator, so rate error stays bounded at any baud. It adds four selectable rates, a run enable, and a synchronous phase restart that RX uses for start-bit alignment.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency in Hz.
- `OVS`, 8: oversample ticks per bit, ≥2.
- `ACC_W`, 24: phase accumulator width, 16..32.
- `BAUD0`, 9600: rate for `baud_sel`=0.
- `BAUD1`, 19200: rate for `baud_sel`=1.
- `BAUD2`, 57600: rate for `baud_sel`=2.
- `BAUD3`, 115200: rate for `baud_sel`=3.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset; assertion is immediate and release is synchronised externally.
- `en`  in  1  run enable; 0 freezes the accumulator and phase.
- `baud_sel`  in  2  requested rate index.
- `restart`  in  1  synchronous phase restart pulse.
- `os_tick`  out  1  oversample tick, one-cycle pulse.
- `bit_tick`  out  1  bit tick, one-cycle pulse, coincident with an `os_tick`.
- `os_phase`  out  $clog2(OVS)  current oversample index within the bit.
- `active_sel`  out  2  rate index currently in use.

## Operation
- Elaboration constants:
  - `INC_k = (BAUD_k*OVS*2^ACC_W + CLK_HZ/2) / CLK_HZ`, evaluated in 64-bit.
  - An elaboration check fails if any `INC_k` is 0 or ≥ 2^ACC_W, i.e. when BAUD_k*OVS ≥ CLK_HZ.
- State: `acc[ACC_W-1:0]`, `os_phase`, `active_sel`, and the registered `os_tick`/`bit_tick`.
- Each edge evaluates conditions in priority order:
  - `restart`=1: `acc`←0, `os_phase`←0, `active_sel`←`baud_sel`, both ticks←0. This applies regardless of `en`.
  - `en`=0: `acc` and `os_phase` hold; `active_sel`←`baud_sel`; both ticks←0.
  - `en`=1: `{carry, acc}`←`acc + INC[active_sel]` (ACC_W+1-bit add, modular wrap).
    - `os_tick`←`carry`.
    - On carry, `os_phase`←(`os_phase`==OVS-1) ? 0 : `os_phase`+1.
    - `bit_tick`←`carry` & (`os_phase`==OVS-1).
- Rate change rule: `active_sel` loads `baud_sel` only on the edge where `carry`=1, or under `restart`/`en`=0. A change requested mid-interval never shortens or stretches the interval in progress.
- Tick spacing: each interval is floor or ceil of 2^ACC_W/INC edges, and the long-run mean equals 2^ACC_W/INC exactly.
- Reset values: `acc`=0, `os_phase`=0, `active_sel`=0, `os_tick`=0, `bit_tick`=0.

## Timing
- Both ticks are registered. Each is high for the one cycle following the edge where the carry occurred.
- `os_phase` updates on that same edge. When `bit_tick`=1, `os_phase` already reads 0.
- After reset release or `restart` with `en`=1, the first `os_tick` rises after ceil(2^ACC_W/INC) enabled edges.
  - 100 MHz, 9600, OVS 8: INC=12885, first tick after 1303 edges; intervals 1302/1303.
  - 115200: INC=154619, first tick after 109 edges; intervals 108/109.
- Ticks never assert in two consecutive cycles, since INC < 2^ACC_W.
- `restart` in the same cycle as a carry: the restart wins and no tick is issued.
- Async reset mid-interval: all outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset values: hold `rst`=0, toggle `clk` → all outputs 0. Release `rst` with `en`=1, `baud_sel`=0 → first `os_tick` at edge 1303; first `bit_tick` together with the 8th `os_tick`.
- Long-run rate: `baud_sel`=0 for 1,000,000 cycles → exactly 768 `os_tick` and 96 `bit_tick`. No two ticks adjacent; every interval is 1302 or 1303.
- Mid-interval rate change: at `baud_sel`=0, switch to 3 at 500 edges after a tick → `active_sel` stays 0 until the next `os_tick` (edge 1302/1303), then becomes 3. Subsequent intervals are 108/109.
- Enable hold: drop `en` for 1000 cycles mid-bit at `os_phase`=5 → no ticks, and `os_phase`=5 held. Re-enable → the remaining accumulator distance is preserved and the tick count resumes with no loss.
- Restart alignment: pulse `restart` at `os_phase`=6, including once on a carry edge → `os_phase`=0 and no tick that cycle. Next `os_tick` arrives 1303 edges later.
- Async reset mid-operation: assert `rst` between edges while `os_phase`=4 → all outputs 0 before the next `clk` edge. After release, the timing repeats from edge 1303.
